// File: rtl/mac_seq.sv
// mac_seq: folded fixed-point dot product (LANES products/beat) with round/saturate and valid/ready handshake
module mac_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int Q_FORMAT = 8,
  parameter int NUM_REGS = 8,
  parameter int LANES = 2,
  parameter int ACC_WIDTH = 2*DATA_WIDTH+$clog2(NUM_REGS),
  parameter bit SATURATE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         startValid,
  output logic                         startReady,
  input  logic signed [DATA_WIDTH-1:0] pDataIn [NUM_REGS],
  input  logic signed [DATA_WIDTH-1:0] coefs [NUM_REGS],
  input  logic                         roundEn,
  output logic                         resultValid,
  input  logic                         resultReady,
  output logic signed [DATA_WIDTH-1:0] macResult,
  output logic                         overflow,
  output logic                         busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, ROUND, HOLD} state_t;
  localparam int BEATS = NUM_REGS/LANES;
  localparam int KW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic signed [ACC_WIDTH-1:0] MAXV = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MINV = {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(1) << (Q_FORMAT-1);
  state_t state_q;
  logic signed [DATA_WIDTH-1:0] data_q [NUM_REGS];
  logic signed [DATA_WIDTH-1:0] coef_q [NUM_REGS];
  logic round_q, ov_q, ov_d;
  logic [KW-1:0] k_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, t, s;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0] res_q, res_d;
  always_comb begin
    acc_d = acc_q;
    prod = '0;
    for (int l = 0; l < LANES; l++) begin
      prod = coef_q[l] * data_q[l];
      acc_d = acc_d + ACC_WIDTH'(prod);
    end
    t = acc_q + (round_q ? RND : '0);
    s = t >>> Q_FORMAT;
    ov_d = s > MAXV || s < MINV;
    res_d = SATURATE && s > MAXV ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
            SATURATE && s < MINV ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : s[DATA_WIDTH-1:0];
  end
  // operands shift down by LANES each beat so lanes always read slots 0..LANES-1
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      k_q <= '0;
      res_q <= '0;
      ov_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (startValid) begin
          data_q <= pDataIn;
          coef_q <= coefs;
          round_q <= roundEn;
          acc_q <= '0;
          k_q <= '0;
          state_q <= ACCUM;
        end
        ACCUM: begin
          acc_q <= acc_d;
          k_q <= k_q + 1'b1;
          for (int i = 0; i < NUM_REGS-LANES; i++) begin
            data_q[i] <= data_q[i+LANES];
            coef_q[i] <= coef_q[i+LANES];
          end
          if (k_q == KW'(BEATS-1)) state_q <= ROUND;
        end
        ROUND: begin
          res_q <= res_d;
          ov_q <= ov_d;
          state_q <= HOLD;
        end
        HOLD: if (resultReady) state_q <= IDLE;
      endcase
    end
  end
  assign startReady = state_q == IDLE;
  assign busy = state_q == ACCUM || state_q == ROUND;
  assign resultValid = state_q == HOLD;
  assign macResult = res_q;
  assign overflow = ov_q;
endmodule
